// File: rtl/memory_layer_controller.sv
// Sequencer for one learning step of a self-organising memory layer: it either inserts a new
// node, or scans for the two nearest nodes and updates them. It drives all memory and mux strobes.
module memory_layer_controller #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_NODES = 64,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish_req,
  input  logic [CNT_W-1:0] node_count,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             ld_upcounter,
  output logic             en_upcounter,
  output logic             en_node_counter,
  output logic             en_connection,
  output logic             en_2min,
  output logic             learning_done,
  output logic             X_c,
  output logic             C_c,
  output logic             W_c,
  output logic             T_c,
  output logic             M_c,
  output logic             rd_wr,
  output logic [1:0]       mux1_sel,
  output logic [1:0]       mux2_sel,
  output logic [1:0]       mux3_sel,
  output logic [1:0]       mux4_sel,
  output logic [1:0]       mux5_sel,
  output logic [1:0]       mux6_sel,
  output logic [1:0]       demux_sel
);

  typedef enum logic [3:0] {
    StIdle, StChk, StIns, StScan, StDrain, StCmp, StRd1, StRd2, StUpd, StConn, StFin
  } state_e;

  localparam logic [2:0]       LatM1 = 3'(READ_LAT - 1);
  localparam logic [2:0]       Lat   = 3'(READ_LAT);
  localparam logic [CNT_W-1:0] Full  = CNT_W'(MAX_NODES);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    scan_q, scan_d;
  logic [2:0]          tmr_q, tmr_d;
  logic [READ_LAT-1:0] dl_q, dl_d;
  logic                overflow_q, overflow_d;
  logic                ldone_q, ldone_d;

  // Read-issue strobe delayed so en_2min lines up with the ED results of each scanned node.
  always_comb begin
    dl_d    = '0;
    dl_d[0] = (state_q == StScan);
    for (int i = 1; i < int'(READ_LAT); i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  assign en_2min       = dl_q[READ_LAT-1];
  assign overflow      = overflow_q;
  assign learning_done = ldone_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    scan_d          = scan_q;
    tmr_d           = tmr_q;
    overflow_d      = overflow_q;
    ldone_d         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    ld_upcounter    = 1'b0;
    en_upcounter    = 1'b0;
    en_node_counter = 1'b0;
    en_connection   = 1'b0;
    X_c             = 1'b0;
    C_c             = 1'b0;
    W_c             = 1'b0;
    T_c             = 1'b0;
    M_c             = 1'b0;
    rd_wr           = 1'b0;
    mux1_sel        = 2'd0;
    mux2_sel        = 2'd0;
    mux3_sel        = 2'd0;
    mux4_sel        = 2'd0;
    mux5_sel        = 2'd0;
    mux6_sel        = 2'd0;
    demux_sel       = 2'd0;

    if (state_q != StIdle && state_q != StFin) busy = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StChk;
        else if (finish_req) ldone_d = 1'b1;
      end
      StChk: begin
        cnt_d = node_count;
        if (node_count == '0) begin
          state_d = StIns;
        end else begin
          ld_upcounter = 1'b1;
          scan_d       = '0;
          state_d      = StScan;
        end
      end
      StIns: begin
        if (cnt_q < Full) begin
          rd_wr           = 1'b1;
          X_c             = 1'b1;
          C_c             = 1'b1;
          W_c             = 1'b1;
          T_c             = 1'b1;
          M_c             = 1'b1;
          en_node_counter = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
        state_d = StFin;
      end
      StScan: begin
        W_c          = 1'b1;
        mux1_sel     = 2'd1;
        en_upcounter = 1'b1;
        scan_d       = scan_q + One;
        if (scan_q + One == cnt_q) begin
          tmr_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tmr_q == LatM1) state_d = StCmp;
        else tmr_d = tmr_q + 3'd1;
      end
      StCmp: begin
        mux5_sel = 2'd2;
        mux6_sel = 2'd2;
        tmr_d    = '0;
        state_d  = cmp_gt ? StIns : StRd1;
      end
      StRd1: begin
        mux1_sel  = 2'd2;
        W_c       = 1'b1;
        T_c       = 1'b1;
        M_c       = 1'b1;
        demux_sel = 2'd1;
        if (tmr_q == Lat) begin
          tmr_d   = '0;
          state_d = (cnt_q == One) ? StUpd : StRd2;
        end else begin
          tmr_d = tmr_q + 3'd1;
        end
      end
      StRd2: begin
        mux1_sel  = 2'd3;
        W_c       = 1'b1;
        demux_sel = 2'd2;
        if (tmr_q == Lat) begin
          tmr_d   = '0;
          state_d = StUpd;
        end else begin
          tmr_d = tmr_q + 3'd1;
        end
      end
      StUpd: begin
        rd_wr = 1'b1;
        if (tmr_q == '0) begin
          mux1_sel = 2'd2;
          mux2_sel = 2'd1;
          mux3_sel = 2'd2;
          mux4_sel = 2'd1;
          W_c      = 1'b1;
          T_c      = 1'b1;
          M_c      = 1'b1;
          if (cnt_q == One) state_d = StConn;
          else tmr_d = 3'd1;
        end else begin
          mux1_sel = 2'd3;
          mux2_sel = 2'd2;
          W_c      = 1'b1;
          state_d  = StConn;
        end
      end
      StConn: begin
        en_connection = (cnt_q >= CNT_W'(2));
        state_d       = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      scan_q     <= '0;
      tmr_q      <= '0;
      dl_q       <= '0;
      overflow_q <= 1'b0;
      ldone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      tmr_q      <= tmr_d;
      dl_q       <= dl_d;
      overflow_q <= overflow_d;
      ldone_q    <= ldone_d;
    end
  end

endmodule

// File: tb/tb_memory_layer_controller.sv
// Scoreboard bench: each step queues its expected strobe counts, latency and overflow; a monitor
// tallies DUT strobes per step and checks them when done pulses.
module tb_memory_layer_controller;

  logic       clk, rst_n, start, finish_req, cmp_gt;
  logic [7:0] node_count;
  logic       busy, done, overflow, ld_upcounter, en_upcounter, en_node_counter, en_connection;
  logic       en_2min, learning_done, X_c, C_c, W_c, T_c, M_c, rd_wr;
  logic [1:0] mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel;

  memory_layer_controller #(.CNT_W(8), .MAX_NODES(64), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish_req(finish_req), .node_count(node_count),
    .cmp_gt(cmp_gt), .busy(busy), .done(done), .overflow(overflow),
    .ld_upcounter(ld_upcounter), .en_upcounter(en_upcounter), .en_node_counter(en_node_counter),
    .en_connection(en_connection), .en_2min(en_2min), .learning_done(learning_done),
    .X_c(X_c), .C_c(C_c), .W_c(W_c), .T_c(T_c), .M_c(M_c), .rd_wr(rd_wr),
    .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .mux3_sel(mux3_sel), .mux4_sel(mux4_sel),
    .mux5_sel(mux5_sel), .mux6_sel(mux6_sel), .demux_sel(demux_sel)
  );

  typedef struct {
    string name;
    int up, mn, ins, upd, wr, nc, conn, ld, lat, ovf, ldone;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: tallies strobes from the first busy cycle and checks at each done.
  initial begin
    int   cyc, rise, f_up, f_mn;
    int   a_up, a_mn, a_ins, a_upd, a_wr, a_nc, a_conn, a_ld, a_ldone;
    logic busy_prev;
    exp_t e;
    cyc = 0; rise = 0; f_up = -1; f_mn = -1; busy_prev = 1'b0;
    a_up = 0; a_mn = 0; a_ins = 0; a_upd = 0; a_wr = 0; a_nc = 0; a_conn = 0; a_ld = 0;
    a_ldone = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_prev) begin
        rise = cyc; f_up = -1; f_mn = -1;
        a_up = 0; a_mn = 0; a_ins = 0; a_upd = 0; a_wr = 0; a_nc = 0; a_conn = 0; a_ld = 0;
        a_ldone = 0;
      end
      if (en_upcounter) begin a_up++; if (f_up < 0) f_up = cyc; end
      if (en_2min) begin a_mn++; if (f_mn < 0) f_mn = cyc; end
      if (rd_wr) a_wr++;
      if (rd_wr && X_c && C_c && W_c && T_c && M_c && mux1_sel == 2'd0 && mux2_sel == 2'd0 &&
          mux3_sel == 2'd0 && mux4_sel == 2'd0) a_ins++;
      if (rd_wr && W_c && T_c && M_c && !X_c && !C_c && mux1_sel == 2'd2 && mux2_sel == 2'd1 &&
          mux3_sel == 2'd2 && mux4_sel == 2'd1) a_upd++;
      if (rd_wr && W_c && !T_c && !M_c && !X_c && !C_c && mux1_sel == 2'd3 &&
          mux2_sel == 2'd2) a_upd++;
      if (en_node_counter) a_nc++;
      if (en_connection) a_conn++;
      if (ld_upcounter) a_ld++;
      if (learning_done) a_ldone++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".en_upcounter"}, a_up, e.up);
          check({e.name, ".en_2min"}, a_mn, e.mn);
          check({e.name, ".ins_writes"}, a_ins, e.ins);
          check({e.name, ".upd_writes"}, a_upd, e.upd);
          check({e.name, ".all_writes"}, a_wr, e.wr);
          check({e.name, ".en_node_counter"}, a_nc, e.nc);
          check({e.name, ".en_connection"}, a_conn, e.conn);
          check({e.name, ".ld_upcounter"}, a_ld, e.ld);
          check({e.name, ".latency"}, cyc - rise + 1, e.lat);
          check({e.name, ".overflow"}, int'(overflow), e.ovf);
          check({e.name, ".learning_done"}, a_ldone, e.ldone);
          if (e.up > 0) check({e.name, ".en_2min_offset"}, f_mn - f_up, 1);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic run_step(input logic [7:0] nc, input logic gt, input logic fin, input exp_t e);
    bit seen;
    @(posedge clk); #1;
    node_count = nc; cmp_gt = gt; start = 1'b1; finish_req = fin;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; finish_req = 1'b0;
    @(posedge clk); #1;
    node_count = ~nc;  // the step must run on the value captured in CHK
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check({e.name, ".done_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end
  endtask

  function automatic exp_t mk(string name, int up, int ins, int upd, int wr, int nc, int conn,
                              int ld, int lat, int ovf, int ldone);
    exp_t e;
    e.name = name; e.up = up; e.mn = up; e.ins = ins; e.upd = upd; e.wr = wr; e.nc = nc;
    e.conn = conn; e.ld = ld; e.lat = lat; e.ovf = ovf; e.ldone = ldone;
    return e;
  endfunction

  initial begin
    int ld_cnt;
    rst_n = 1'b0; start = 1'b0; finish_req = 1'b0; cmp_gt = 1'b0; node_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({busy, done, overflow, rd_wr, W_c, en_2min, learning_done, mux1_sel}), 0);
    rst_n = 1'b1;

    //                name        up ins upd wr nc conn ld lat ovf ldone
    run_step(8'd0,  1'b0, 1'b0, mk("empty",     0, 1, 0, 1, 1, 0, 0,  3, 0, 0));
    run_step(8'd5,  1'b0, 1'b0, mk("n5_upd",    5, 0, 2, 2, 0, 1, 1, 16, 0, 0));
    run_step(8'd2,  1'b0, 1'b0, mk("n2_upd",    2, 0, 2, 2, 0, 1, 1, 13, 0, 0));
    run_step(8'd5,  1'b1, 1'b0, mk("n5_ins",    5, 1, 0, 1, 1, 0, 1, 10, 0, 0));
    run_step(8'd64, 1'b1, 1'b0, mk("full",     64, 0, 0, 0, 0, 0, 1, 69, 1, 0));
    run_step(8'd3,  1'b1, 1'b0, mk("after_ovf", 3, 1, 0, 1, 1, 0, 1,  8, 1, 0));
    run_step(8'd1,  1'b0, 1'b0, mk("n1_upd",    1, 0, 1, 1, 0, 0, 1,  9, 1, 0));

    // finish_req alone in IDLE gives a single learning_done pulse
    @(posedge clk); #1 finish_req = 1'b1;
    @(posedge clk); #1 finish_req = 1'b0;
    ld_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (learning_done) ld_cnt++;
    end
    check("finish_alone.learning_done", ld_cnt, 1);

    // Reset asserted in the third SCAN cycle
    @(posedge clk); #1;
    node_count = 8'd5; cmp_gt = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_scan.en_upcounter", int'(en_upcounter), 1);
    rst_n = 1'b0;
    #1;
    check("mid_scan_reset.outputs",
          int'({busy, done, overflow, ld_upcounter, en_upcounter, en_node_counter, en_connection,
                en_2min, learning_done, X_c, C_c, W_c, T_c, M_c, rd_wr}), 0);
    check("mid_scan_reset.selects",
          int'({mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_step(8'd0,  1'b0, 1'b1, mk("post_reset", 0, 1, 0, 1, 1, 0, 0,  3, 0, 0));
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_layer_controller.md
MEMORY_LAYER_CONTROLLER -- requirements
Module: memory_layer_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the node index and node count width.
REQ-002 The block SHALL have parameter MAX_NODES, default 64, which sets the node capacity per class.
REQ-003 The block SHALL have parameter READ_LAT, default 1, which is the cycles from memory read issue to a valid ED result (range 1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin one learning step for the presented x and c.
REQ-007 The block SHALL have port finish_req, input, 1 bit: host request to end learning.
REQ-008 The block SHALL have port node_count, input, CNT_W bits: the current node count of class c.
REQ-009 The block SHALL have port cmp_gt, input, 1 bit: comparator result, 1 when min1_ED > Ths1.
REQ-010 The block SHALL have port busy, output, 1 bit: a step is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at step end.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, insertion refused because the class is full.
REQ-013 The block SHALL have outputs ld_upcounter, en_upcounter, en_node_counter, en_connection, en_2min and learning_done, each 1 bit: datapath strobes.
REQ-014 The block SHALL have outputs X_c, C_c, W_c, T_c and M_c, each 1 bit: memory field enables.
REQ-015 The block SHALL have output rd_wr, 1 bit: 0 = read, 1 = write.
REQ-016 The block SHALL have outputs mux1_sel through mux6_sel and demux_sel, each 2 bits: datapath selects.

Function
REQ-017 The block SHALL implement states IDLE, CHK, INS, SCAN, DRAIN, CMP, RD1, RD2, UPD, CONN and FIN.
REQ-018 In IDLE, when start=1, the block SHALL go to CHK and raise busy the next cycle; start SHALL be ignored in any other state.
REQ-019 In IDLE, when finish_req=1 and start=0, the block SHALL pulse learning_done for one cycle; if start=1 and finish_req=1 together, start SHALL win and finish_req SHALL be dropped.
REQ-020 CHK: if node_count==0, the block SHALL go to INS; otherwise it SHALL assert ld_upcounter for one cycle and go to SCAN.
REQ-021 INS, when node_count<MAX_NODES: for one cycle the block SHALL assert rd_wr=1, X_c=C_c=W_c=T_c=M_c=1, mux1_sel=0 (new index), mux2_sel=0 (x), mux3_sel=0 (initial threshold) and mux4_sel=0 (M=1), pulse en_node_counter, then go to FIN.
REQ-022 INS, when node_count==MAX_NODES: the block SHALL perform no write and no en_node_counter, set overflow, and go to FIN.
REQ-023 SCAN SHALL last exactly node_count cycles, each with rd_wr=0, W_c=1, mux1_sel=1, demux_sel=0 and en_upcounter=1; an internal counter SHALL track issued reads.
REQ-024 en_2min SHALL equal the SCAN read-issue strobe delayed by exactly READ_LAT cycles through a shift register.
REQ-025 DRAIN SHALL last READ_LAT cycles, then the block SHALL go to CMP.
REQ-026 CMP SHALL drive mux5_sel=2 (Ths1) and mux6_sel=2 (min1_ED) and sample cmp_gt at the end of the cycle; cmp_gt=1 SHALL go to INS, cmp_gt=0 SHALL go to RD1.
REQ-027 RD1 SHALL read the min1 node with mux1_sel=2, W_c=T_c=M_c=1 and demux_sel=1 for READ_LAT+1 cycles.
REQ-028 RD2 SHALL read the min2 node with mux1_sel=3, W_c=1 and demux_sel=2 for READ_LAT+1 cycles.
REQ-029 When node_count==1, RD2 SHALL be skipped.
REQ-030 UPD SHALL last 2 cycles with rd_wr=1: cycle 1 writes min1 (mux1_sel=2, mux2_sel=1, mux3_sel=2, mux4_sel=1, W_c=T_c=M_c=1); cycle 2 writes min2 weight (mux1_sel=3, mux2_sel=2, W_c=1).
REQ-031 When node_count==1, UPD SHALL be 1 cycle.
REQ-032 CONN SHALL pulse en_connection for one cycle and only when node_count>=2; it SHALL then go to FIN.
REQ-033 FIN SHALL pulse done and return to IDLE; busy SHALL drop in the same cycle done is high.
REQ-034 Unused selects SHALL be driven 0; rd_wr SHALL be 0 and all field enables SHALL be 0 whenever no access is defined.
REQ-035 overflow SHALL clear only on reset.
REQ-036 node_count SHALL be sampled into a register in CHK and held constant for the rest of the step.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, clear the scan counter and delay line, and set every output and overflow to 0, including mid-step with no write completed afterward.
REQ-038 After rst_n rises, the first start SHALL be accepted on the next clock edge.

Verification
REQ-039 node_count=0, start -> CHK, then INS with all field enables and en_node_counter for 1 cycle; done 3 cycles after start.
REQ-040 node_count=5, READ_LAT=1, cmp_gt=0 -> exactly 5 en_upcounter cycles, en_2min pulses offset +1 cycle, 2 UPD writes, 1 en_connection, done.
REQ-041 node_count=5, cmp_gt=1 -> no UPD and no en_connection; INS write at index 5; one en_node_counter.
REQ-042 node_count=MAX_NODES, cmp_gt=1 -> no write, overflow=1 held through the next steps, done still pulses.
REQ-043 node_count=1, cmp_gt=0 -> RD2 skipped, 1 UPD write, no en_connection.
REQ-044 rst_n low during SCAN cycle 3 -> all outputs 0 at once; the next start restarts cleanly; start with finish_req together -> no learning_done.
